// File: rtl/meas_cmd_regfile.sv
// meas_cmd_regfile: SPI command decoder and register file for the pulse-measurement core.
// Optional build macro CMD_PARITY_EN enables the even-parity check on each command word.
module meas_cmd_regfile #(
    parameter int          DATA_W   = 32,
    parameter int          NUM_CH   = 4,
    parameter int          NUM_CFG  = 4,
    parameter int          CFG_BASE = 12,
    parameter logic [31:0] ID_WORD  = 32'h0000_5AA5,
    parameter logic [31:0] CFG0_RST = 32'd5_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         spi_cmd,
    input  logic                      spi_trig,
    input  logic [NUM_CH*DATA_W-1:0]  meas_data,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_valid,
    output logic [NUM_CFG*DATA_W-1:0] cfg_data,
    output logic                      busy
);
    typedef enum logic [2:0] {IDLE, DECODE, WRITE, READ, ERR} state_t;
    state_t state;
    logic s1, s2, s3, trig_edge;
    logic [DATA_W-1:0] cmd_q, meas_sel, cfg_sel, rd_word;
    logic [DATA_W-1:0] cfg [NUM_CFG];
    logic drop_flag;
    logic [7:0] err_cnt, err_code;
    logic [3:0] op, addr;
    logic [31:0] a32;
    logic is_meas, is_cfg, rd_ok, par_err;
    assign trig_edge = s2 & ~s3;
    assign busy = state != IDLE;
    for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg
        assign cfg_data[i*DATA_W +: DATA_W] = cfg[i];
    end
    always_comb begin
        op = cmd_q[31:28];
        addr = cmd_q[27:24];
        a32 = {28'd0, addr};
        is_meas = 1'b0;
        is_cfg = 1'b0;
        meas_sel = '0;
        cfg_sel = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (a32 == 32'(k)) begin
                is_meas = 1'b1;
                meas_sel = meas_data[k*DATA_W +: DATA_W];
            end
        for (int k = 0; k < NUM_CFG; k++)
            if (a32 == 32'(CFG_BASE + k)) begin
                is_cfg = 1'b1;
                cfg_sel = cfg[k];
            end
        rd_ok = is_meas | is_cfg | (addr == 4'd8) | (addr == 4'd9);
        rd_word = is_meas ? meas_sel : is_cfg ? cfg_sel : (addr == 4'd8) ? ID_WORD :
                  {16'd0, err_cnt, 7'd0, drop_flag};
`ifdef CMD_PARITY_EN
        par_err = ^cmd_q;
`else
        par_err = 1'b0;
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s3, s2, s1} <= 3'b000;
            state <= IDLE;
            cmd_q <= '0;
            rsp_data <= '0;
            rsp_valid <= 1'b0;
            drop_flag <= 1'b0;
            err_cnt <= 8'd0;
            err_code <= 8'd0;
            for (int k = 0; k < NUM_CFG; k++) cfg[k] <= (k == 0) ? CFG0_RST : '0;
        end else begin
            {s3, s2, s1} <= {s2, s1, spi_trig};
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (trig_edge) begin
                    cmd_q <= spi_cmd;
                    state <= DECODE;
                end
                DECODE: begin
                    state <= ERR;
                    err_code <= 8'h02;
                    if (par_err) err_code <= 8'h03;
                    else if (op == 4'd4 && is_cfg) state <= WRITE;
                    else if (op == 4'd5 && rd_ok) state <= READ;
                    else if (op != 4'd4 && op != 4'd5) err_code <= 8'h01;
                end
                WRITE: begin
                    for (int k = 0; k < NUM_CFG; k++)
                        if (a32 == 32'(CFG_BASE + k)) cfg[k] <= {8'd0, cmd_q[23:0]};
                    rsp_data <= {8'd0, cmd_q[23:0]};
                    rsp_valid <= 1'b1;
                    state <= IDLE;
                end
                READ: begin
                    rsp_data <= rd_word;
                    if (addr == 4'd9) drop_flag <= 1'b0;
                    rsp_valid <= 1'b1;
                    state <= IDLE;
                end
                ERR: begin
                    rsp_data <= {16'hEEEE, 8'h00, err_code};
                    err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                    rsp_valid <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // placed after the status-read clear so a coincident drop still sets the flag
            if (trig_edge && state != IDLE) drop_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_meas_cmd_regfile.sv
// tb_meas_cmd_regfile: randomized scoreboard bench for meas_cmd_regfile against a register-map model.
module tb_meas_cmd_regfile;
    localparam int NUM_CH = 4, NUM_CFG = 4, CFG_BASE = 12;
    localparam logic [31:0] ID_WORD = 32'h0000_5AA5, CFG0_RST = 32'd5_000_000;
    logic clk = 1'b0, rst, spi_trig, rsp_valid, busy;
    logic [31:0] spi_cmd, rsp_data;
    logic [NUM_CH*32-1:0] meas_data;
    logic [NUM_CFG*32-1:0] cfg_data;
    typedef struct {logic [31:0] data; int cyc;} exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] m_cfg [NUM_CFG];
    logic [31:0] m_meas [NUM_CH];
    int m_err;
    logic m_drop;

    meas_cmd_regfile dut (.clk(clk), .rst(rst), .spi_cmd(spi_cmd), .spi_trig(spi_trig),
        .meas_data(meas_data), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .cfg_data(cfg_data), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp got %h want none", rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_data", rsp_data, mon_e.data);
                chk("rsp_latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    function automatic logic [31:0] err(input logic [7:0] code);
        m_err = (m_err < 255) ? m_err + 1 : 255;
        return {24'hEEEE_00, code};
    endfunction

    function automatic logic [31:0] model(input logic [31:0] cmd);
        int op = int'(cmd[31:28]);
        int a = int'(cmd[27:24]);
        logic [31:0] s;
`ifdef CMD_PARITY_EN
        if (^cmd) return err(8'h03);
`endif
        if (op == 4) begin
            if (a >= CFG_BASE && a < CFG_BASE + NUM_CFG) begin
                m_cfg[a-CFG_BASE] = {8'd0, cmd[23:0]};
                return {8'd0, cmd[23:0]};
            end
            return err(8'h02);
        end
        if (op == 5) begin
            if (a < NUM_CH) return m_meas[a];
            if (a == 8) return ID_WORD;
            if (a == 9) begin
                s = {16'd0, 8'(m_err), 7'd0, m_drop};
                m_drop = 1'b0;
                return s;
            end
            if (a >= CFG_BASE && a < CFG_BASE + NUM_CFG) return m_cfg[a-CFG_BASE];
            return err(8'h02);
        end
        return err(8'h01);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CFG; k++) m_cfg[k] = (k == 0) ? CFG0_RST : 32'd0;
        m_err = 0;
        m_drop = 1'b0;
    endtask

    task automatic set_meas(input int k, input logic [31:0] v);
        m_meas[k] = v;
        meas_data[k*32 +: 32] = v;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout got none want %0d responses", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_cfg();
        for (int k = 0; k < NUM_CFG; k++) chk("cfg_data", cfg_data[k*32 +: 32], m_cfg[k]);
    endtask

    // the internal edge lands two cycles after spi_trig is raised, response three cycles later
    task automatic send(input logic [31:0] cmd, input int hold);
        logic [31:0] e;
        @(negedge clk);
        e = model(cmd);
        exp_q.push_back('{e, cyc + 5});
        spi_cmd = cmd;
        spi_trig = 1'b1;
        repeat (hold) @(negedge clk);
        spi_trig = 1'b0;
        drain();
    endtask

    initial begin
        rst = 1'b1;
        spi_trig = 1'b0;
        spi_cmd = '0;
        meas_data = '0;
        for (int k = 0; k < NUM_CH; k++) m_meas[k] = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        check_cfg();

        send(32'h5800_0000, 1);
        send(32'h5C00_0000, 1);
        send(32'h4C98_9680, 1);
        check_cfg();
        send(32'h5C00_0000, 1);
        set_meas(2, 32'h1234_5678);
        send(32'h5200_0000, 1);
        send(32'h5500_0000, 1);
        send(32'h7000_0000, 1);
        send(32'h4800_0001, 1);
        send(32'h5900_0000, 1);
        send(32'h5D00_00AA, 10);

        // second rising edge arrives while the first command is executing
        @(negedge clk);
        spi_cmd = 32'h5800_0000;
        exp_q.push_back('{model(spi_cmd), cyc + 5});
        spi_trig = 1'b1;
        @(negedge clk);
        spi_trig = 1'b0;
        @(negedge clk);
        spi_trig = 1'b1;
        m_drop = 1'b1;
        repeat (3) @(negedge clk);
        spi_trig = 1'b0;
        drain();
        send(32'h5900_0000, 1);
        send(32'h5900_0000, 1);

        repeat (300) send(32'h7000_0000, 1);
        send(32'h5900_0000, 1);

        for (int i = 0; i < 200; i++) begin
            int r = int'($urandom_range(0, 3));
            logic [3:0] op = (r < 2) ? 4'd5 : (r == 2) ? 4'd4 : 4'($urandom);
            if (i % 10 == 0) set_meas(int'($urandom_range(0, NUM_CH - 1)), $urandom);
            send({op, 4'($urandom), 24'($urandom)}, int'($urandom_range(1, 4)));
        end
        check_cfg();

        // asynchronous reset while the command sits in DECODE
        send(32'h4D00_0123, 1);
        @(negedge clk);
        spi_cmd = 32'h4C00_0777;
        spi_trig = 1'b1;
        @(negedge clk);
        spi_trig = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_mid_cmd", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (10) @(negedge clk);
        chk("abort_rsp_data", rsp_data, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        check_cfg();
        send(32'h5D00_0000, 1);
        send(32'h5900_0000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
